conv_acc_regs: RTL and testbench

CONV_ACC_REGS -- requirements
Module: conv_acc_regs

---
 rtl/conv_acc_regs.sv | 190 +++++++++++++++++++
 tb/tb_conv_acc_regs.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_regs.sv
// AXI4-Lite register block for the convolution accelerator: shape/requant parameters,
// enable/start control and a busy/done status handshake with the accelerator core.
module conv_acc_regs #(
  parameter int TENSOR_W   = 8,
  parameter int KERNEL_W   = 4,
  parameter int CHANNELS_W = 8,
  parameter int STRIDE_W   = 2,
  parameter int KNUMS_W    = 8,
  parameter int SHIFT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [4:0]            s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  enable,
  output logic                  conv_en,
  input  logic                  conv_done,
  output logic [TENSOR_W-1:0]   axi_tensor_size,
  output logic [KERNEL_W-1:0]   axi_kernel_size,
  output logic [CHANNELS_W-1:0] axi_channels,
  output logic [STRIDE_W-1:0]   axi_stride,
  output logic [KNUMS_W-1:0]    axi_kernel_nums,
  output logic [SHIFT_W-1:0]    shift
);

  logic        live;
  logic        aw_full, w_full;
  logic [2:0]  aw_idx;
  logic [31:0] w_data;
  logic        w_strb0;
  logic        busy, done;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic        wr_err, field_wr, en_wr, start_go, done_clr;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], s_wstrb[3:1], w_data[31:8]};

  // live gates the readies so they stay low through reset and rise on the first free edge
  assign s_awready = live & ~aw_full & ~s_bvalid;
  assign s_wready  = live & ~w_full & ~s_bvalid;
  assign s_arready = live & ~s_rvalid;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign ar_hs  = s_arvalid & s_arready;
  assign commit = aw_full & w_full & ~s_bvalid;

  always_comb begin
    wr_err   = 1'b0;
    field_wr = 1'b0;
    en_wr    = 1'b0;
    start_go = 1'b0;
    done_clr = 1'b0;
    if (commit) begin
      case (aw_idx)
        3'd0: begin
          if (w_strb0) begin
            en_wr = 1'b1;
            if (w_data[1]) begin
              if (busy || !w_data[0]) wr_err = 1'b1;
              else                    start_go = 1'b1;
            end
          end
        end
        3'd7: done_clr = w_strb0 & w_data[1];
        default: begin
          if (busy)         wr_err   = 1'b1;
          else if (w_strb0) field_wr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (s_araddr[4:2])
      3'd0: rd_word = {31'd0, enable};
      3'd1: rd_word = 32'(axi_tensor_size);
      3'd2: rd_word = 32'(axi_kernel_size);
      3'd3: rd_word = 32'(axi_channels);
      3'd4: rd_word = 32'(axi_stride);
      3'd5: rd_word = 32'(axi_kernel_nums);
      3'd6: rd_word = 32'(shift);
      3'd7: rd_word = {30'd0, done, busy};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live            <= 1'b0;
      aw_full         <= 1'b0;
      w_full          <= 1'b0;
      aw_idx          <= '0;
      w_data          <= '0;
      w_strb0         <= 1'b0;
      s_bvalid        <= 1'b0;
      s_bresp         <= '0;
      s_rvalid        <= 1'b0;
      s_rresp         <= '0;
      s_rdata         <= '0;
      enable          <= 1'b0;
      conv_en         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      axi_tensor_size <= '0;
      axi_kernel_size <= '0;
      axi_channels    <= '0;
      axi_stride      <= '0;
      axi_kernel_nums <= '0;
      shift           <= '0;
    end else begin
      live    <= 1'b1;
      conv_en <= start_go;

      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s_awaddr[4:2];
      end
      if (w_hs) begin
        w_full  <= 1'b1;
        w_data  <= s_wdata;
        w_strb0 <= s_wstrb[0];
      end
      if (commit) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_err ? 2'b10 : 2'b00;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
      end

      if (field_wr) begin
        case (aw_idx)
          3'd1: axi_tensor_size <= w_data[TENSOR_W-1:0];
          3'd2: axi_kernel_size <= w_data[KERNEL_W-1:0];
          3'd3: axi_channels    <= w_data[CHANNELS_W-1:0];
          3'd4: axi_stride      <= w_data[STRIDE_W-1:0];
          3'd5: axi_kernel_nums <= w_data[KNUMS_W-1:0];
          3'd6: shift           <= w_data[SHIFT_W-1:0];
          default: ;
        endcase
      end

      // Later assignments take priority: completion over W1C, then disable, then start
      if (done_clr) done <= 1'b0;
      if (conv_done && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (en_wr) begin
        enable <= w_data[0];
        if (!w_data[0] && busy) begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      end
      if (start_go) begin
        busy <= 1'b1;
        done <= 1'b0;
      end

      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_word;
        s_rresp  <= 2'b00;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_acc_regs.sv
// Self-checking bench for conv_acc_regs: randomized AXI-Lite traffic against a
// register-map model, plus directed start/done, error, stall and reset scenarios.
module tb_conv_acc_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [4:0]  s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic        enable, conv_en, conv_done;
  logic [7:0]  axi_tensor_size;
  logic [3:0]  axi_kernel_size;
  logic [7:0]  axi_channels;
  logic [1:0]  axi_stride;
  logic [7:0]  axi_kernel_nums;
  logic [4:0]  shift;

  conv_acc_regs #(
    .TENSOR_W(8), .KERNEL_W(4), .CHANNELS_W(8), .STRIDE_W(2), .KNUMS_W(8), .SHIFT_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .enable(enable), .conv_en(conv_en), .conv_done(conv_done),
    .axi_tensor_size(axi_tensor_size), .axi_kernel_size(axi_kernel_size),
    .axi_channels(axi_channels), .axi_stride(axi_stride),
    .axi_kernel_nums(axi_kernel_nums), .shift(shift)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (conv_en === 1'b1) pulse_cnt++;

  // Register-map model: word index -> stored field value
  bit          m_enable, m_busy, m_done;
  int unsigned m_reg [8];
  int unsigned m_mask[8] = '{0, 255, 15, 255, 3, 255, 31, 0};

  task automatic model_reset();
    m_enable = 0; m_busy = 0; m_done = 0;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
  endtask

  task automatic model_write(input int unsigned idx, input logic [31:0] d, input bit strb,
                             output logic [1:0] resp, output bit pulse);
    resp = 2'b00; pulse = 0;
    if (idx == 0) begin
      if (strb) begin
        if (d[1]) begin
          if (m_busy || !d[0]) resp = 2'b10;
          else                 pulse = 1;
        end
        m_enable = d[0];
        if (!d[0]) begin m_busy = 0; m_done = 0; end
        if (pulse) begin m_busy = 1; m_done = 0; end
      end
    end else if (idx == 7) begin
      if (strb && d[1]) m_done = 0;
    end else if (m_busy) begin
      resp = 2'b10;
    end else if (strb) begin
      m_reg[idx] = d & m_mask[idx];
    end
  endtask

  function automatic logic [31:0] model_read(input int unsigned idx);
    if (idx == 0) return {31'd0, m_enable};
    if (idx == 7) return {30'd0, m_done, m_busy};
    return m_reg[idx];
  endfunction

  task automatic idle_inputs();
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0; conv_done = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic en_at_b);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got_b = 0;
    int c = 0;
    s_bready = 1;
    while (!(aw_done && w_done) && c < 50) begin
      if (!aw_done && c >= aw_dly) begin s_awvalid = 1; s_awaddr = addr; end
      if (!w_done && c >= w_dly) begin s_wvalid = 1; s_wdata = data; s_wstrb = strb; end
      @(negedge clk);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; s_awvalid = 0; end
      if (w_hs)  begin w_done = 1;  s_wvalid = 0;  end
      c++;
    end
    if (!(aw_done && w_done)) begin
      n_tests++; n_fail++;
      $display("FAIL write_accept addr=%h aw=%0b w=%0b required both accepted", addr, aw_done, w_done);
    end
    resp = 2'bxx; en_at_b = 1'bx; c = 0;
    while (!got_b && c < 20) begin
      @(negedge clk);
      if (s_bvalid === 1'b1) begin
        resp = s_bresp; en_at_b = conv_en; got_b = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!got_b) begin
      n_tests++; n_fail++;
      $display("FAIL write_bvalid_timeout addr=%h bvalid=%b required 1", addr, s_bvalid);
    end
    s_bready = 0; s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, ar_hs, got_r = 0;
    int c = 0;
    s_rready = 1; s_araddr = addr; s_arvalid = 1;
    while (!ar_done && c < 20) begin
      @(negedge clk);
      ar_hs = s_arvalid && s_arready;
      @(posedge clk); #1;
      if (ar_hs) begin ar_done = 1; s_arvalid = 0; end
      c++;
    end
    s_arvalid = 0;
    data = 'x; resp = 'x; c = 0;
    while (ar_done && !got_r && c < 20) begin
      @(negedge clk);
      if (s_rvalid === 1'b1) begin data = s_rdata; resp = s_rresp; got_r = 1; end
      @(posedge clk); #1;
      c++;
    end
    if (!got_r) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", addr, s_rvalid);
    end
    s_rready = 0;
  endtask

  task automatic pulse_done();
    conv_done = 1;
    @(posedge clk); #1;
    conv_done = 0;
    if (m_busy) begin m_busy = 0; m_done = 1; end
  endtask

  logic [1:0]  resp, exp_resp;
  logic [31:0] rdat;
  logic        en_b;
  bit          exp_pulse;
  int          p0;

  task automatic test_reset();
    rst = 1; idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, enable, conv_en} !== 7'd0 ||
        {s_bresp, s_rresp, s_rdata} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b%b%b bv=%b rv=%b en=%b ce=%b rdata=%h required all 0",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid, enable, conv_en, s_rdata);
    end
    n_tests++;
    if ({axi_tensor_size, axi_kernel_size, axi_channels, axi_stride, axi_kernel_nums, shift} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_fields got %h required 0",
               {axi_tensor_size, axi_kernel_size, axi_channels, axi_stride, axi_kernel_nums, shift});
    end
    rst = 0; model_reset();
    @(posedge clk); #1;
    n_tests++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b required 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_w_before_aw();
    axi_write(5'h04, 32'h0000001C, 4'hF, 3, 0, resp, en_b);
    model_write(1, 32'h1C, 1, exp_resp, exp_pulse);
    n_tests++;
    if (resp !== 2'b00) begin n_fail++; $display("FAIL wfirst_bresp got %b required 00", resp); end
    n_tests++;
    if (axi_tensor_size !== 8'd28) begin n_fail++; $display("FAIL wfirst_tensor got %0d required 28", axi_tensor_size); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (s_bvalid !== 1'b0) begin n_fail++; $display("FAIL wfirst_single_b got bvalid=%b required 0", s_bvalid); end
    axi_read(5'h04, rdat, resp);
    n_tests++;
    if (rdat !== 32'h1C || resp !== 2'b00) begin
      n_fail++; $display("FAIL wfirst_readback got %h/%b required 0000001c/00", rdat, resp);
    end
  endtask

  task automatic test_random_regs();
    for (int i = 0; i < 24; i++) begin
      int unsigned idx;
      logic [4:0]  addr;
      logic [31:0] d;
      logic [3:0]  st;
      idx  = $urandom_range(1, 6);
      addr = {idx[2:0], 2'($urandom)};
      d    = $urandom;
      st   = 4'($urandom);
      axi_write(addr, d, st, $urandom_range(0, 3), $urandom_range(0, 3), resp, en_b);
      model_write(idx, d, st[0], exp_resp, exp_pulse);
      n_tests++;
      if (resp !== exp_resp) begin n_fail++; $display("FAIL rand_bresp[%0d] got %b required %b", i, resp, exp_resp); end
      n_tests++;
      if (32'(axi_tensor_size) !== m_reg[1] || 32'(axi_kernel_size) !== m_reg[2] ||
          32'(axi_channels) !== m_reg[3] || 32'(axi_stride) !== m_reg[4] ||
          32'(axi_kernel_nums) !== m_reg[5] || 32'(shift) !== m_reg[6]) begin
        n_fail++;
        $display("FAIL rand_fields[%0d] got %h %h %h %h %h %h required %h %h %h %h %h %h", i,
                 axi_tensor_size, axi_kernel_size, axi_channels, axi_stride, axi_kernel_nums, shift,
                 m_reg[1], m_reg[2], m_reg[3], m_reg[4], m_reg[5], m_reg[6]);
      end
      idx  = $urandom_range(0, 7);
      addr = {idx[2:0], 2'($urandom)};
      axi_read(addr, rdat, resp);
      n_tests++;
      if (rdat !== model_read(idx) || resp !== 2'b00) begin
        n_fail++; $display("FAIL rand_read[%0d] addr=%h got %h/%b required %h/00", i, addr, rdat, resp, model_read(idx));
      end
    end
  endtask

  task automatic test_start_done();
    p0 = pulse_cnt;
    axi_write(5'h00, 32'h3, 4'hF, 0, 0, resp, en_b);
    model_write(0, 32'h3, 1, exp_resp, exp_pulse);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (resp !== 2'b00 || enable !== 1'b1 || en_b !== 1'b1 || pulse_cnt - p0 != 1) begin
      n_fail++; $display("FAIL start_pulse got resp=%b en=%b conv_en@B=%b pulses=%0d required 00/1/1/1",
                         resp, enable, en_b, pulse_cnt - p0);
    end
    axi_read(5'h1C, rdat, resp);
    n_tests++;
    if (rdat !== model_read(7) || rdat !== 32'h1) begin n_fail++; $display("FAIL start_status got %h required 00000001", rdat); end
    pulse_done();
    axi_read(5'h1C, rdat, resp);
    n_tests++;
    if (rdat !== 32'h2) begin n_fail++; $display("FAIL done_status got %h required 00000002", rdat); end
    axi_write(5'h1C, 32'h2, 4'hF, 0, 0, resp, en_b);
    model_write(7, 32'h2, 1, exp_resp, exp_pulse);
    axi_read(5'h1C, rdat, resp);
    n_tests++;
    if (rdat !== 32'h0 || resp !== 2'b00) begin n_fail++; $display("FAIL done_w1c got %h required 00000000", rdat); end
  endtask

  task automatic test_busy_errors();
    logic [1:0] stride_before;
    axi_write(5'h00, 32'h3, 4'hF, 0, 0, resp, en_b);
    model_write(0, 32'h3, 1, exp_resp, exp_pulse);
    stride_before = axi_stride;
    axi_write(5'h10, 32'h3, 4'hF, 1, 0, resp, en_b);
    model_write(4, 32'h3, 1, exp_resp, exp_pulse);
    n_tests++;
    if (resp !== 2'b10 || axi_stride !== stride_before) begin
      n_fail++; $display("FAIL busy_param got resp=%b stride=%0d required 10/%0d", resp, axi_stride, stride_before);
    end
    p0 = pulse_cnt;
    axi_write(5'h00, 32'h3, 4'hF, 0, 1, resp, en_b);
    model_write(0, 32'h3, 1, exp_resp, exp_pulse);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (resp !== 2'b10 || pulse_cnt != p0) begin
      n_fail++; $display("FAIL busy_restart got resp=%b pulses=%0d required 10/0", resp, pulse_cnt - p0);
    end
    pulse_done();
    axi_read(5'h1C, rdat, resp);
    n_tests++;
    if (rdat !== model_read(7)) begin n_fail++; $display("FAIL busy_finish got %h required %h", rdat, model_read(7)); end
  endtask

  task automatic test_strb0();
    do_reset();
    axi_write(5'h18, 32'h7, 4'h0, 0, 0, resp, en_b);
    model_write(6, 32'h7, 0, exp_resp, exp_pulse);
    n_tests++;
    if (resp !== 2'b00 || shift !== 5'd0) begin
      n_fail++; $display("FAIL strb0 got resp=%b shift=%0d required 00/0", resp, shift);
    end
  endtask

  task automatic test_enable_clear();
    axi_write(5'h00, 32'h3, 4'hF, 0, 0, resp, en_b);
    model_write(0, 32'h3, 1, exp_resp, exp_pulse);
    axi_write(5'h00, 32'h0, 4'hF, 0, 0, resp, en_b);
    model_write(0, 32'h0, 1, exp_resp, exp_pulse);
    n_tests++;
    if (resp !== 2'b00 || enable !== 1'b0) begin n_fail++; $display("FAIL disable got resp=%b en=%b required 00/0", resp, enable); end
    pulse_done();
    axi_read(5'h1C, rdat, resp);
    n_tests++;
    if (rdat !== 32'h0) begin n_fail++; $display("FAIL disable_status got %h required 00000000", rdat); end
  endtask

  task automatic test_done_coincide();
    s_awaddr = 5'h00; s_wdata = 32'h3; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1; s_bready = 0;
    @(negedge clk);
    n_tests++;
    if ({s_awready, s_wready} !== 2'b11) begin n_fail++; $display("FAIL coincide_accept got %b required 11", {s_awready, s_wready}); end
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; conv_done = 1;
    @(posedge clk); #1;
    conv_done = 0;
    model_write(0, 32'h3, 1, exp_resp, exp_pulse);
    n_tests++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || conv_en !== 1'b1) begin
      n_fail++; $display("FAIL coincide_start got bv=%b resp=%b ce=%b required 1/00/1", s_bvalid, s_bresp, conv_en);
    end
    s_bready = 1;
    @(posedge clk); #1;
    s_bready = 0;
    axi_read(5'h1C, rdat, resp);
    n_tests++;
    if (rdat !== 32'h1) begin n_fail++; $display("FAIL coincide_status got %h required 00000001", rdat); end
    pulse_done();
  endtask

  task automatic test_stall();
    logic [31:0] old_v, new_v;
    old_v = model_read(1);
    new_v = old_v ^ 32'h5A;
    s_awaddr = 5'h04; s_wdata = new_v; s_wstrb = 4'h1; s_awvalid = 1; s_wvalid = 1;
    s_bready = 0; s_rready = 0;
    @(negedge clk);
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; s_araddr = 5'h04; s_arvalid = 1;
    @(negedge clk);
    n_tests++;
    if (s_arready !== 1'b1) begin n_fail++; $display("FAIL stall_ar_accept got %b required 1", s_arready); end
    @(posedge clk); #1;
    s_arvalid = 0;
    model_write(1, new_v, 1, exp_resp, exp_pulse);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (s_bvalid !== 1'b1 || s_rvalid !== 1'b1 || s_bresp !== 2'b00 || s_rdata !== old_v ||
          s_rresp !== 2'b00 || {s_awready, s_wready, s_arready} !== 3'b000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got bv=%b rv=%b bresp=%b rdata=%h rdy=%b required 1/1/00/%h/000",
                 i, s_bvalid, s_rvalid, s_bresp, s_rdata, {s_awready, s_wready, s_arready}, old_v);
      end
      @(posedge clk); #1;
    end
    s_bready = 1; s_rready = 1;
    @(posedge clk); #1;
    s_bready = 0; s_rready = 0;
    n_tests++;
    if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || 32'(axi_tensor_size) !== new_v) begin
      n_fail++; $display("FAIL stall_release got bv=%b rv=%b tensor=%h required 0/0/%h", s_bvalid, s_rvalid, axi_tensor_size, new_v);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_b = 0;
    s_awaddr = 5'h08; s_wdata = 32'h9; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1; s_bready = 0;
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0;
    @(posedge clk); #1;
    n_tests++;
    if (s_bvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pending got bvalid=%b required 1", s_bvalid); end
    rst = 1;
    @(posedge clk); #1;
    n_tests++;
    if (s_bvalid !== 1'b0 || s_bresp !== 2'b00 || {s_awready, s_wready, s_arready} !== 3'b000 ||
        enable !== 1'b0 || {axi_tensor_size, axi_kernel_size, axi_channels, axi_stride, axi_kernel_nums, shift} !== 35'd0) begin
      n_fail++; $display("FAIL midrst_state got bv=%b rdy=%b en=%b kernel=%h required 0/000/0/0",
                         s_bvalid, {s_awready, s_wready, s_arready}, enable, axi_kernel_size);
    end
    rst = 0; model_reset();
    s_bready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_bvalid !== 1'b0) seen_b = 1;
    end
    @(posedge clk); #1;
    s_bready = 0;
    n_tests++;
    if (seen_b || {s_awready, s_wready, s_arready} !== 3'b111) begin
      n_fail++; $display("FAIL midrst_after got late_b=%b rdy=%b required 0/111", seen_b, {s_awready, s_wready, s_arready});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_w_before_aw();
    test_random_regs();
    test_start_done();
    test_busy_errors();
    test_strb0();
    test_enable_clear();
    test_done_coincide();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
